// File: rtl/fetch_unit.sv
// Instruction fetch unit: walks pc through an 8x16 registered-read RAM and hands
// one word at a time to a consumer, while sharing the RAM port with host writes.
module fetch_unit #(
    parameter int PC_WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_addr,
    output logic [15:0]         instr,
    output logic [PC_WIDTH-1:0] instr_addr,
    output logic                instr_valid,
    input  logic                instr_ready,
    input  logic                wr_en,
    input  logic [2:0]          wr_addr,
    input  logic [15:0]         wr_data,
    output logic                wr_ack,
    output logic [2:0]          mem_address,
    output logic                mem_load,
    output logic [15:0]         mem_in,
    input  logic [15:0]         mem_out
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0]          state;
    logic [PC_WIDTH-1:0] pc;
    logic                port_free;

    // The RAM port is only free for host writes when no read is in flight.
    assign port_free   = (state == IDLE) || (state == HOLD);
    assign wr_ack      = reset_n && wr_en && port_free && !jump;
    assign mem_load    = wr_ack;
    assign mem_address = wr_ack ? wr_addr : pc[2:0];
    assign mem_in      = wr_data;
    assign instr_valid = (state == HOLD);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            pc         <= '0;
            instr      <= '0;
            instr_addr <= '0;
        end else if (jump) begin
            // Any fetch in flight or word being held is dropped on a jump.
            pc    <= jump_addr;
            state <= run ? ISSUE : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (run) state <= ISSUE;
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    instr      <= mem_out;
                    instr_addr <= pc;
                    pc         <= pc + PC_WIDTH'(1);
                    state      <= HOLD;
                end
                default: begin
                    if (instr_ready) state <= run ? ISSUE : IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural 8x16 registered-read RAM.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run;
    logic        jump;
    logic [15:0] jump_addr;
    logic [15:0] instr;
    logic [15:0] instr_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic [2:0]  mem_address;
    logic        mem_load;
    logic [15:0] mem_in;
    logic [15:0] mem_out;

    logic [15:0] ram [0:7];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_load) ram[mem_address] <= mem_in;
        mem_out <= ram[mem_address];
    end

    fetch_unit #(.PC_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .jump(jump), .jump_addr(jump_addr),
        .instr(instr), .instr_addr(instr_addr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .mem_address(mem_address), .mem_load(mem_load),
        .mem_in(mem_in), .mem_out(mem_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!instr_valid && cyc < 20) begin
            step();
            cyc++;
        end
        checks++;
        if (!instr_valid) begin
            failures++;
            $display("FAIL wait_valid timeout: instr_valid=%0b required 1", instr_valid);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; run = 1'b0; jump = 1'b1; jump_addr = 16'h0042;
        instr_ready = 1'b0; wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h1234;
        step(); step();
        #1;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b want 0", instr_valid); end
        checks++; if (instr !== 16'h0000) begin failures++; $display("FAIL reset_instr: got %h want 0000", instr); end
        checks++; if (instr_addr !== 16'h0000) begin failures++; $display("FAIL reset_instr_addr: got %h want 0000", instr_addr); end
        checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL reset_wr_ack: got %0b want 0", wr_ack); end
        checks++; if (mem_load !== 1'b0) begin failures++; $display("FAIL reset_mem_load: got %0b want 0", mem_load); end
        jump = 1'b0; wr_en = 1'b0;
        reset_n = 1'b1;
        #1;
        checks++; if (mem_address !== 3'd0) begin failures++; $display("FAIL reset_pc_addr: got %0d want 0", mem_address); end
    endtask

    task automatic test_preload();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 16'h1000 + 16'(i);
            #1;
            checks++;
            if (wr_ack !== 1'b1 || mem_load !== 1'b1 || mem_address !== 3'(i) || mem_in !== 16'h1000 + 16'(i)) begin
                failures++;
                $display("FAIL preload_%0d: ack=%0b load=%0b addr=%0d in=%h want 1 1 %0d %h",
                         i, wr_ack, mem_load, mem_address, mem_in, i, 16'h1000 + 16'(i));
            end
            step();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_stream();
        int cyc;
        run = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wait_valid(cyc);
            checks++;
            if (instr !== 16'h1000 + 16'(i % 8) || instr_addr !== 16'(i)) begin
                failures++;
                $display("FAIL stream_%0d: instr=%h addr=%h want %h %h", i, instr, instr_addr,
                         16'h1000 + 16'(i % 8), 16'(i));
            end
            if (i > 0) begin
                checks++;
                if (cyc != 2) begin failures++; $display("FAIL stream_rate_%0d: gap=%0d want 2", i, cyc); end
            end
            if (i == 8) run = 1'b0;
            step();
        end
        checks++;
        if (instr_valid !== 1'b0 || mem_address !== 3'd1) begin
            failures++;
            $display("FAIL stream_idle: valid=%0b addr=%0d want 0 1", instr_valid, mem_address);
        end
    endtask

    task automatic test_hold_stall();
        int cyc;
        run = 1'b1; instr_ready = 1'b0;
        wait_valid(cyc);
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (instr_valid !== 1'b1 || instr !== 16'h1001 || instr_addr !== 16'd9 || mem_address !== 3'd2) begin
                failures++;
                $display("FAIL stall_%0d: valid=%0b instr=%h addr=%h pc_lo=%0d want 1 1001 0009 2",
                         k, instr_valid, instr, instr_addr, mem_address);
            end
        end
        instr_ready = 1'b1;
        step();
        checks++;
        if (instr_valid !== 1'b0) begin failures++; $display("FAIL stall_accept: valid=%0b want 0", instr_valid); end
    endtask

    task automatic test_jump_wait();
        int cyc;
        step();
        jump = 1'b1; jump_addr = 16'h0005;
        step();
        jump = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || instr_addr !== 16'd9 || instr !== 16'h1001 || mem_address !== 3'd5) begin
            failures++;
            $display("FAIL jump_wait_drop: valid=%0b instr=%h addr=%h pc_lo=%0d want 0 1001 0009 5",
                     instr_valid, instr, instr_addr, mem_address);
        end
        wait_valid(cyc);
        checks++;
        if (instr !== 16'h1005 || instr_addr !== 16'h0005 || cyc != 2) begin
            failures++;
            $display("FAIL jump_wait_fetch: instr=%h addr=%h gap=%0d want 1005 0005 2", instr, instr_addr, cyc);
        end
    endtask

    task automatic test_write_hold();
        int cyc;
        jump = 1'b1; jump_addr = 16'h0002;
        step();
        jump = 1'b0;
        checks++;
        if (instr_valid !== 1'b0) begin failures++; $display("FAIL jump_hold_drop: valid=%0b want 0", instr_valid); end
        wait_valid(cyc);
        checks++;
        if (instr !== 16'h1002 || instr_addr !== 16'h0002) begin
            failures++;
            $display("FAIL write_hold_pre: instr=%h addr=%h want 1002 0002", instr, instr_addr);
        end
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF;
        #1;
        checks++;
        if (wr_ack !== 1'b1 || mem_load !== 1'b1 || mem_address !== 3'd3) begin
            failures++;
            $display("FAIL write_hold_ack: ack=%0b load=%0b addr=%0d want 1 1 3", wr_ack, mem_load, mem_address);
        end
        step();
        wr_addr = 3'd6; wr_data = 16'h6666;
        #1;
        checks++;
        if (wr_ack !== 1'b0 || mem_load !== 1'b0) begin
            failures++;
            $display("FAIL write_issue_block: ack=%0b load=%0b want 0 0", wr_ack, mem_load);
        end
        step();
        checks++;
        if (wr_ack !== 1'b0) begin failures++; $display("FAIL write_wait_block: ack=%0b want 0", wr_ack); end
        step();
        checks++;
        if (instr_valid !== 1'b1 || instr !== 16'hBEEF || instr_addr !== 16'h0003 || wr_ack !== 1'b1) begin
            failures++;
            $display("FAIL write_hold_post: valid=%0b instr=%h addr=%h ack=%0b want 1 beef 0003 1",
                     instr_valid, instr, instr_addr, wr_ack);
        end
        step();
        wr_en = 1'b0;
    endtask

    task automatic test_wrap();
        int cyc;
        jump = 1'b1; jump_addr = 16'hFFFF;
        step();
        jump = 1'b0;
        wait_valid(cyc);
        checks++;
        if (instr !== 16'h1007 || instr_addr !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_last: instr=%h addr=%h want 1007 ffff", instr, instr_addr);
        end
        step();
        wait_valid(cyc);
        checks++;
        if (instr !== 16'h1000 || instr_addr !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_first: instr=%h addr=%h want 1000 0000", instr, instr_addr);
        end
    endtask

    task automatic test_reset_hold();
        int cyc;
        instr_ready = 1'b0;
        reset_n = 1'b0; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hDEAD;
        #1;
        checks++;
        if (wr_ack !== 1'b0 || mem_load !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold_nowrite: ack=%0b load=%0b want 0 0", wr_ack, mem_load);
        end
        step();
        reset_n = 1'b1; wr_en = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || instr !== 16'h0000 || instr_addr !== 16'h0000 || mem_address !== 3'd0) begin
            failures++;
            $display("FAIL reset_hold_state: valid=%0b instr=%h addr=%h pc_lo=%0d want 0 0000 0000 0",
                     instr_valid, instr, instr_addr, mem_address);
        end
        instr_ready = 1'b1;
        wait_valid(cyc);
        checks++;
        if (instr !== 16'h1000 || instr_addr !== 16'h0000 || cyc != 3) begin
            failures++;
            $display("FAIL reset_hold_refetch: instr=%h addr=%h gap=%0d want 1000 0000 3", instr, instr_addr, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_stream();
        test_hold_stall();
        test_jump_wait();
        test_write_hold();
        test_wrap();
        test_reset_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
